// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard/forwarding unit: mux selects,
// scoreboard entry layout {v, rd, rf_e, ld} and the PC register index.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam int SB_LD_BIT   = 0;
  localparam int SB_RF_E_BIT = 1;
  localparam int SB_RD_LSB   = 2;

  function automatic int sb_v_bit(input int reg_aw);
    return reg_aw + 2;
  endfunction

  function automatic int sb_entry_w(input int reg_aw);
    return reg_aw + 3;
  endfunction

  // PC is the highest register address (R15 for a 16-entry file).
  function automatic int pc_reg_idx(input int reg_aw);
    return (1 << reg_aw) - 1;
  endfunction

  localparam int PC_REG_IDX = 15;

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage: a plain register holding a packed {v, rd, rf_e, ld}
// entry, cleared asynchronously so no stale producer survives reset.
module hazard_sb_entry #(
  parameter int EW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [EW-1:0] entry_nxt,
  output logic [EW-1:0] entry
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) entry <= '0;
    else        entry <= entry_nxt;
  end

endmodule

// File: rtl/pipe_hazard_fwd_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations for EX/MEM/WB,
// picks the youngest forwarding source per ID operand and raises load-use stalls.
module pipe_hazard_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 3,
  parameter int FWD_STAGES = 3,
  parameter int SEL_W      = 2,
  parameter bit EXCL_PC    = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_rf_e,
  input  logic                      id_load,
  input  logic                      flush,
  input  logic                      cnt_clr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic                      nop_ex,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int EW     = sb_entry_w(REG_AW);
  localparam int V_BIT  = sb_v_bit(REG_AW);
  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(pc_reg_idx(REG_AW));

  logic [FWD_STAGES-1:0][EW-1:0]     sb_d;
  logic [FWD_STAGES-1:0][EW-1:0]     sb_q;
  logic [EW-1:0]                     entry_head;
  logic [FWD_STAGES-1:0]             ent_v;
  logic [FWD_STAGES-1:0]             ent_rf_e;
  logic [FWD_STAGES-1:0][REG_AW-1:0] ent_rd;
  logic [NUM_SRC-1:0][FWD_STAGES-1:0] match;
  logic                              lu_hit;
  logic                              unused_ld_tail;

  // Stalled or flushed ID instructions enter EX as a bubble.
  assign entry_head = {id_valid & ~stall & ~flush, id_rd, id_rf_e, id_load};

  for (genvar g = 0; g < FWD_STAGES; g++) begin : g_sb
    if (g == 0) begin : g_head
      assign sb_d[g] = entry_head;
    end else begin : g_tail
      assign sb_d[g] = sb_q[g-1];
    end
    hazard_sb_entry #(.EW(EW)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .entry_nxt (sb_d[g]),
      .entry     (sb_q[g])
    );
  end

  assign unused_ld_tail = sb_q[FWD_STAGES-1][SB_LD_BIT];

  always_comb begin
    for (int i = 0; i < FWD_STAGES; i++) begin
      ent_v[i]    = sb_q[i][V_BIT];
      ent_rf_e[i] = sb_q[i][SB_RF_E_BIT];
      ent_rd[i]   = sb_q[i][SB_RD_LSB +: REG_AW];
    end
  end

  always_comb begin
    logic [REG_AW-1:0] addr;
    logic              is_pc;
    match = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      addr  = id_src_addr[k*REG_AW +: REG_AW];
      is_pc = EXCL_PC && (addr == PC_ADDR);
      for (int i = 0; i < FWD_STAGES; i++) begin
        match[k][i] = id_src_used[k] & ent_v[i] & ent_rf_e[i] &
                      (ent_rd[i] == addr) & ~is_pc;
      end
    end
  end

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
      for (int i = FWD_STAGES - 1; i >= 0; i--) begin
        if (match[k][i]) fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(i + 1);
      end
    end
  end

  // Only a load still in EX stalls; from MEM its data is forwardable.
  always_comb begin
    lu_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) lu_hit = lu_hit | match[k][0];
  end

  assign stall  = id_valid & sb_q[0][SB_LD_BIT] & lu_hit & ~flush;
  assign nop_ex = stall | flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       stall_cnt <= '0;
    else if (cnt_clr)                 stall_cnt <= '0;
    else if (stall && !(&stall_cnt))  stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/pipe_hazard_fwd_unit.md
Name: pipe_hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage ARM-subset pipeline (IF, ID, EX, MEM, WB).
- Keeps its own scoreboard of in-flight destination registers. The scoreboard is a shift chain that mirrors the ID/EX, EX/MEM and MEM/WB registers.
- From the scoreboard it generates:
  - a forwarding select for each operand mux in ID (PA, PB, PD and any others);
  - a load-use stall;
  - bubble insertion into EX.
- Generalises the fixed three-source, three-stage hazard scheme to N sources, M forwarding stages, a configurable register-file width and optional PC-register exclusion. Adds flush support and a stall statistics counter.

Parameters:
- REG_AW, 4, register-address width (16 registers).
- NUM_SRC, 3, number of ID operand read ports (PA, PB, PD).
- FWD_STAGES, 3, number of tracked downstream stages. Entry 0 = EX, 1 = MEM, 2 = WB.
- SEL_W, 2, forwarding-select width. Must be at least clog2(FWD_STAGES+1).
- EXCL_PC, 1, when 1 the register at address 2^REG_AW-1 (R15) is never forwarded and never causes a stall.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real (non-NOP) instruction.
- id_src_addr  in  NUM_SRC*REG_AW  source register addresses; source k occupies bits [k*REG_AW +: REG_AW].
- id_src_used  in  NUM_SRC  source k is actually read by the ID instruction.
- id_rd  in  REG_AW  destination register (instr I15..I12).
- id_rf_e  in  1  ID instruction writes the register file.
- id_load  in  1  ID instruction is a load.
- flush  in  1  branch taken; kill the ID instruction.
- cnt_clr  in  1  synchronous clear of the stall counter.
- fwd_sel  out  NUM_SRC*SEL_W  per-source mux select: 0 = register file, 1 = EX, 2 = MEM, 3 = WB.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- nop_ex  out  1  bubble being inserted into EX this cycle.
- stall_cnt  out  CNT_W  number of stall cycles since reset or clear.

Behaviour:
- Scoreboard: FWD_STAGES entries, each holding {v, rd, rf_e, ld}. Updated on the rising edge of clk.
  - entry[i] <= entry[i-1] for i >= 1.
  - entry[0] <= {id_valid & ~stall & ~flush, id_rd, id_rf_e, id_load}.
  - The chain never stalls. Downstream stages always advance.
- Reset (reset = 0, asynchronous):
  - all entries cleared (v = 0);
  - stall_cnt = 0.
  - The combinational outputs therefore settle to fwd_sel = 0, stall = 0 and nop_ex = 0.
- Match for source k at stage i: id_src_used[k] & entry[i].v & entry[i].rf_e & (entry[i].rd == src_addr[k]).
  - When EXCL_PC = 1, an address equal to all-ones never matches.
- fwd_sel[k] (combinational):
  - the lowest i with a match gives fwd_sel = i+1, so the youngest producer wins;
  - no match gives 0.
- Load-use: entry[0].ld & match(k, 0) for any k, gated by id_valid, sets stall = 1.
  - Load data is available from MEM, so a load in entry[1] is forwarded with fwd_sel = 2 and does not stall.
- stall is combinational on the ID inputs and registered scoreboard state, with zero-cycle latency to the PC and IF/ID enables.
  - stall lasts exactly one cycle per load-use hazard.
  - After that cycle the bubble sits in EX and the load sits in MEM, so the recomputed fwd_sel = 2.
- nop_ex = stall | flush.
- flush has priority:
  - when flush = 1, stall is forced to 0 and entry[0] receives a bubble;
  - stall_cnt does not increment.
- stall_cnt increments on each clock with stall = 1 and saturates at all-ones.
  - cnt_clr = 1 clears it to 0. cnt_clr wins over an increment in the same cycle.
- Multiple sources may select the same stage in the same cycle.
- A source matching a stage whose rf_e = 0 falls through to the next older stage.
- Reset asserted mid-stall discards all in-flight entries immediately. The first cycle after release has no hazards.

Decomposition:
- Shared package pipe_pkg holds:
  - the FWD_RF / FWD_EX / FWD_MEM / FWD_WB select constants;
  - the scoreboard entry field widths;
  - the PC register index constant.
- One natural sub-module, hazard_sb_entry: a single scoreboard stage register with asynchronous active-low reset, instantiated FWD_STAGES times in a generate loop.
- Priority encoding and stall logic stay in the top-level module.

Test Plan:
- ADD R1 then SUB R2,R1,R3 back-to-back (src0 = 1, used) -> cycle 2: fwd_sel[0] = 1 (EX), stall = 0. With one intervening NOP -> fwd_sel[0] = 2. With two NOPs -> fwd_sel[0] = 3.
- LDR R5 then ADD R6,R5,R5 -> cycle 2: stall = 1, nop_ex = 1, stall_cnt 0->1. Cycle 3: stall = 0, fwd_sel[0] = fwd_sel[1] = 2.
- ADD R4 then MOV R4, followed by a reader of R4 -> fwd_sel = 1 (youngest wins), not 2. Also: a store (rf_e = 0) targeting R4 in EX with ADD R4 in MEM -> fwd_sel = 2.
- Reader of R15 while R15 is a destination in EX, with EXCL_PC = 1 -> fwd_sel = 0, stall = 0.
- LDR R5 hazard asserted together with flush = 1 -> stall = 0, nop_ex = 1, stall_cnt unchanged, entry[0].v = 0 on the next cycle.
- Reset pulled low during a stall cycle -> stall and fwd_sel drop to 0 asynchronously, stall_cnt = 0. Separately: force 65535 stall cycles -> stall_cnt saturates at 16'hFFFF; cnt_clr = 1 -> 0.
